// File: rtl/fpu_cvt_to_float_pkg.sv
// Shared FPU definitions: rounding modes, single-precision field
// widths, exponent bias and the int-to-float converter FSM states.
package fpu_cvt_to_float_pkg;

    localparam int unsigned FP_EXP_BIAS = 127;
    localparam int unsigned FP_EXP_W    = 8;
    localparam int unsigned FP_MAN_W    = 23;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } cvt_state_e;

endpackage

// File: rtl/cvrt_rounder.sv
// LGRS rounding decision: lgrs_i={L,G,R,S}, rm_i, sign_i -> round_o.
// round_o is the raw mode decision; callers gate it with G|R|S.
module cvrt_rounder
    import fpu_cvt_to_float_pkg::*;
(
    input  logic [3:0] lgrs_i,
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    output logic       round_o
);

    logic l, g, r, s;

    assign {l, g, r, s} = lgrs_i;

    always_comb begin
        round_o = 1'b0;
        case (rm_i)
            RM_RNE:  round_o = g & (r | s | l);
            RM_RTZ:  round_o = 1'b0;
            RM_RDN:  round_o = sign_i;
            RM_RUP:  round_o = ~sign_i;
            RM_RMM:  round_o = g;
            default: round_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_cvt_to_float.sv
// Iterative FCVT.S.W / FCVT.S.WU: normalise one bit per cycle, round.
// Ports: in_valid_i/in_ready_o + int_a_i/is_unsigned_i/rounding_mode_i
// in; out_valid_o/out_ready_i + result_o/inexact_o out.
module fpu_cvt_to_float
    import fpu_cvt_to_float_pkg::*;
#(
    parameter int unsigned EXP_BIAS = FP_EXP_BIAS
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] int_a_i,
    input  logic        is_unsigned_i,
    input  logic [2:0]  rounding_mode_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        inexact_o
);

    localparam logic [FP_EXP_W-1:0] START_EXP =
        FP_EXP_W'(EXP_BIAS + 32'd31);

    cvt_state_e          state_q, state_d;
    logic                sign_q, sign_d;
    logic [31:0]         mag_q, mag_d;
    logic [FP_EXP_W-1:0] exp_q, exp_d;
    logic [2:0]          rm_q, rm_d;
    logic [31:0]         result_q, result_d;
    logic                nx_q, nx_d;

    logic                l, g, r, s, grs;
    logic                round_req, inc, carry;
    logic [FP_MAN_W-1:0] frac;
    logic [FP_EXP_W-1:0] exp_rnd;

    assign l   = mag_q[8];
    assign g   = mag_q[7];
    assign r   = mag_q[6];
    assign s   = |mag_q[5:0];
    assign grs = g | r | s;

    cvrt_rounder u_rounder (
        .lgrs_i  ({l, g, r, s}),
        .rm_i    (rm_q),
        .sign_i  (sign_q),
        .round_o (round_req)
    );

    // An exact value must never be bumped by a directed mode.
    assign inc   = round_req & grs;
    // mag_q[31] is set in ROUND, so a carry out of the 24-bit
    // significand happens only when the 23 fraction bits are all ones;
    // the 23-bit add then wraps the fraction to zero by itself.
    assign carry = inc & (&mag_q[30:8]);
    assign frac  = mag_q[30:8] + FP_MAN_W'(inc);
    assign exp_rnd = exp_q + FP_EXP_W'(carry);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        rm_d     = rm_q;
        result_d = result_q;
        nx_d     = nx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    sign_d = ~is_unsigned_i & int_a_i[31];
                    mag_d  = sign_d ? -int_a_i : int_a_i;
                    exp_d  = START_EXP;
                    rm_d   = rounding_mode_i;
                    if (mag_d == '0) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        nx_d     = 1'b0;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                result_d = {sign_q, exp_rnd, frac};
                nx_d     = grs;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            rm_q     <= '0;
            result_q <= '0;
            nx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            nx_q     <= nx_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign result_o    = result_q;
    assign inexact_o   = nx_q;

endmodule

// File: tb/tb_fpu_cvt_to_float.sv
// Self-checking bench for fpu_cvt_to_float: scoreboard of expected
// results, latency, backpressure and mid-operation reset.
module tb_fpu_cvt_to_float;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] int_a = '0;
    logic        is_uns = 1'b0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        inexact;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        nx;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fpu_cvt_to_float dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .int_a_i         (int_a),
        .is_unsigned_i   (is_uns),
        .rounding_mode_i (rm),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .result_o        (result),
        .inexact_o       (inexact)
    );

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    // Cycles from accept edge (counted as 1) to out_valid: 34-k.
    function automatic int exp_lat(input logic [31:0] a,
                                   input logic uns);
        logic [31:0] m;
        int k;
        m = (!uns && a[31]) ? -a : a;
        if (m == 0) return 1;
        k = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) k = i;
        return 34 - k;
    endfunction

    task automatic run_op(input string name,
                          input logic [31:0] a,
                          input logic uns,
                          input logic [2:0] mode,
                          input logic [31:0] er,
                          input logic enx,
                          input int hold);
        exp_t e;
        exp_t o;
        int cyc;
        logic [31:0] held;
        e.res = er;
        e.nx  = enx;
        e.lat = exp_lat(a, uns);
        sb.push_back(e);
        int_a    = a;
        is_uns   = uns;
        rm       = mode;
        in_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        in_valid = 1'b0;
        int_a    = 32'hDEAD_BEEF;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        o = sb.pop_front();
        chk({name, "_res"}, result, o.res);
        chk({name, "_nx"}, 32'(inexact), 32'(o.nx));
        chk({name, "_lat"}, 32'(cyc), 32'(o.lat));
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, "_hold_res"}, result, held);
            chk({name, "_hold_vld"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_rel_vld"}, 32'(out_valid), 32'd0);
        chk({name, "_rel_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_nx", 32'(inexact), 32'd0);
        reset = 1'b0;

        run_op("s_one", 32'h0000_0001, 0, RNE, 32'h3F80_0000, 0, 0);
        run_op("s_m1", 32'hFFFF_FFFF, 0, RNE, 32'hBF80_0000, 0, 0);
        run_op("u_max_rne", 32'hFFFF_FFFF, 1, RNE,
               32'h4F80_0000, 1, 0);
        run_op("u_max_rtz", 32'hFFFF_FFFF, 1, RTZ,
               32'h4F7F_FFFF, 1, 0);
        run_op("tie_rne", 32'h0100_0001, 0, RNE, 32'h4B80_0000, 1, 0);
        run_op("tie_rup", 32'h0100_0001, 0, RUP, 32'h4B80_0001, 1, 0);
        run_op("tie_rmm", 32'h0100_0001, 0, RMM, 32'h4B80_0001, 1, 0);
        run_op("s_min", 32'h8000_0000, 0, RNE, 32'hCF00_0000, 0, 0);
        run_op("exact_rup", 32'h0000_0100, 0, RUP,
               32'h4380_0000, 0, 0);
        run_op("zero", 32'h0000_0000, 0, RNE, 32'h0000_0000, 0, 5);
        run_op("neg_rup", 32'hFEFF_FFFF, 0, RUP, 32'hCB80_0000, 1, 0);

        // Mid-NORM reset: result_o currently holds a nonzero value.
        int_a    = 32'h0000_0001;
        is_uns   = 1'b0;
        rm       = RNE;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_res", result, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_out", 32'(out_valid), 32'd0);
        run_op("after_rst", 32'h0000_0002, 0, RNE, 32'h4000_0000, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_cvt_to_float.md
Name: fpu_cvt_to_float

Overview:
- Iterative integer-to-single-precision converter for FCVT.S.W and FCVT.S.WU; the reverse direction of the float-to-int path in the FPU arithmetic sub-modules.
- Accepts a 32-bit signed or unsigned integer over a valid/ready handshake.
- Normalises the magnitude one bit per cycle, then rounds using the FPU's LGRS rounding convention.
- Holds the IEEE-754 result until the consumer accepts it.

Parameters:
- EXP_BIAS, 127, single-precision exponent bias. The starting exponent is EXP_BIAS+31.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept an operand
- int_a_i  in  32  integer operand
- is_unsigned_i  in  1  1 = treat int_a_i as unsigned (WU); 0 = two's complement (W)
- rounding_mode_i  in  3  RISC-V rm, already resolved (DYN replaced upstream)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  32  IEEE-754 single result
- inexact_o  out  1  NX flag; valid with out_valid_o

Behaviour:
- Clock and reset: one clock. reset_i is synchronous and active-high.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, inexact_o=0, all internal registers 0.
- Reset mid-operation: the block returns to IDLE on the next edge. The in-flight operand is discarded and no result is produced.
- States: IDLE, NORM, ROUND, DONE. in_ready_o=1 only in IDLE.
- IDLE, on in_valid_i & in_ready_o:
  - sign = ~is_unsigned_i & int_a_i[31].
  - mag = sign ? -int_a_i : int_a_i, 32-bit.
  - exp = EXP_BIAS+31 = 158. Latch rm.
  - If mag==0: go to DONE with result=0x00000000 and NX=0. A zero result is always +0.
  - Otherwise go to NORM.
- NORM, each cycle:
  - If mag[31]==0: mag<<=1, exp-=1, stay in NORM.
  - If mag[31]==1: go to ROUND.
  - No shift limit is needed, because mag≠0.
- ROUND, one cycle:
  - L=mag[8], G=mag[7], R=mag[6], S=|mag[5:0].
  - Rounding decision by rm:
    - 000 RNE: round if G&(R|S|L).
    - 001 RTZ: no round.
    - 010 RDN: round if sign.
    - 011 RUP: round if ~sign.
    - 100 RMM: round if G.
    - 101/110/111: no round.
  - inc = decision & (G|R|S). Directed modes must never round an exact value.
  - {carry,frac} = mag[31:8] + inc, 25-bit. If carry, exp+=1 and frac=0.
  - result = {sign, exp[7:0], frac[22:0]}. NX = G|R|S.
  - Go to DONE.
- Range: the maximum exponent is 159 (2^32), so overflow to infinity is impossible and no NV or OF flag is produced.
- DONE:
  - out_valid_o=1; result_o and inexact_o are stable.
  - On out_ready_i: out_valid_o=0, go to IDLE. A new operand can be accepted the next cycle; there is no same-cycle accept.
  - out_ready_i asserted before DONE has no effect.
- Latency: for a nonzero input whose magnitude has its MSB at bit k, out_valid_o rises 34-k cycles after the accept edge.
  - Magnitude 1: 34 cycles.
  - Magnitude 0x80000000: 3 cycles.
  - Zero input: 1 cycle.
- Throughput: one conversion in flight at a time.

Decomposition:
- Shared FPU package:
  - rm encodings RNE/RTZ/RDN/RUP/RMM.
  - EXP_BIAS, single-precision field widths.
  - FSM state encodings.
- Sub-module: reuse the existing cvrt_rounder (LGRS, rm, sign -> round_out). Gate its output with G|R|S locally.
- FSM and datapath stay in one module.

Test Plan:
- Sign, latency and exact path, RNE:
  - Signed 0x00000001 -> 0x3F800000, NX=0, out_valid_o exactly 34 cycles after accept.
  - Signed 0xFFFFFFFF -> 0xBF800000.
- Unsigned all-ones:
  - Unsigned 0xFFFFFFFF, RNE -> 0x4F800000 (carry, exp 159), NX=1.
  - Same operand, RTZ -> 0x4F7FFFFF, NX=1.
- Tie-to-even and directed rounding on 0x01000001 (signed):
  - RNE -> 0x4B800000, NX=1.
  - RUP -> 0x4B800001.
  - RMM -> 0x4B800001.
- Exact value under directed modes:
  - Signed 0x80000000 -> 0xCF000000, NX=0, 3-cycle latency.
  - Signed 0x00000100 with RUP -> 0x43800000, NX=0 (no spurious increment).
- Zero and backpressure:
  - Input 0 -> 0x00000000 one cycle after accept.
  - Hold out_ready_i=0 for 5 cycles -> result stable, in_ready_o=0.
  - Release -> IDLE next cycle.
- Reset mid-NORM:
  - Accept 0x00000001, assert reset_i at cycle 10 -> next edge out_valid_o=0, in_ready_o=1, result_o=0.
  - A new operand 0x00000002 then converts to 0x40000000.
